// File: rtl/axi4_dummy_pkg.sv
// Shared types and constants for the AXI4 dummy (error-responder) slave.
// Response codes and the read-channel FSM state encoding.
package axi4_dummy_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4_dummy_slave_sync_fifo.sv
// Small synchronous FIFO with registered count and a first-word-fall-through head.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: it is only visible when count_q != 0.
    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/axi4_dummy_slave.sv
// AXI4 error-responder slave: accepts every request, answers each with RESP_CODE.
// B and R responses follow acceptance order; all outputs come from registers.
module axi4_dummy_slave
    import axi4_dummy_pkg::*;
#(
    parameter int                        AXI_ID_WIDTH     = 4,
    parameter int                        AXI_ADDR_WIDTH   = 32,
    parameter int                        AXI_DATA_WIDTH   = 64,
    parameter int                        OUTSTANDING_WREQ = 8,
    parameter int                        OUTSTANDING_RREQ = 8,
    parameter logic [1:0]                RESP_CODE        = 2'b10,
    parameter logic [AXI_DATA_WIDTH-1:0] RDATA_FILL       = '0
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXI_ID_WIDTH-1:0]     s_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]                  s_awlen,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                        s_wlast,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    output logic [AXI_ID_WIDTH-1:0]     s_bid,
    output logic [1:0]                  s_bresp,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    input  logic [AXI_ID_WIDTH-1:0]     s_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]                  s_arlen,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    output logic [AXI_ID_WIDTH-1:0]     s_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rlast,
    output logic                        s_rvalid,
    input  logic                        s_rready
);

    // An OKAY code would make this slave look mapped; fall back to SLVERR.
    localparam logic [1:0] RESP =
        (RESP_CODE == AXI_RESP_DECERR) ? AXI_RESP_DECERR :
        (RESP_CODE == AXI_RESP_OKAY)   ? AXI_RESP_SLVERR :
                                         AXI_RESP_SLVERR;

    localparam int WCW = $clog2(OUTSTANDING_WREQ + 1);
    localparam int ARW = AXI_ID_WIDTH + 8;

    logic unused_inputs;
    assign unused_inputs = ^{s_awaddr, s_awlen, s_wdata, s_wstrb, s_araddr};

    logic                 aw_full, aw_empty;
    logic                 aw_hs, wlast_hs, b_hs;
    logic [WCW-1:0]       wburst_cnt_q, wburst_cnt_d;

    assign s_awready = !aw_full;
    assign s_wready  = (wburst_cnt_q < WCW'(OUTSTANDING_WREQ));
    assign s_bvalid  = !aw_empty && (wburst_cnt_q != '0);
    assign s_bresp   = RESP;
    assign aw_hs     = s_awvalid && s_awready;
    assign wlast_hs  = s_wvalid && s_wready && s_wlast;
    assign b_hs      = s_bvalid && s_bready;

    sync_fifo #(
        .WIDTH (AXI_ID_WIDTH),
        .DEPTH (OUTSTANDING_WREQ)
    ) u_aw_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (aw_hs),
        .wdata   (s_awid),
        .pop     (b_hs),
        .rdata   (s_bid),
        .full    (aw_full),
        .empty   (aw_empty)
    );

    always_comb begin
        wburst_cnt_d = wburst_cnt_q;
        case ({wlast_hs, b_hs})
            2'b10:   wburst_cnt_d = wburst_cnt_q + 1'b1;
            2'b01:   wburst_cnt_d = wburst_cnt_q - 1'b1;
            default: wburst_cnt_d = wburst_cnt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wburst_cnt_q <= '0;
        end else begin
            wburst_cnt_q <= wburst_cnt_d;
        end
    end

    logic                    ar_full, ar_empty;
    logic [ARW-1:0]          ar_head;
    logic                    ar_hs, r_hs;
    logic                    ar_push, ar_pop, bypass;
    rd_state_t               state_q, state_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic [AXI_ID_WIDTH-1:0] rid_q, rid_d;

    assign s_arready = !ar_full;
    assign ar_hs     = s_arvalid && s_arready;
    assign r_hs      = s_rvalid && s_rready;
    assign ar_push   = ar_hs && !bypass;

    sync_fifo #(
        .WIDTH (ARW),
        .DEPTH (OUTSTANDING_RREQ)
    ) u_ar_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (ar_push),
        .wdata   ({s_arid, s_arlen}),
        .pop     (ar_pop),
        .rdata   (ar_head),
        .full    (ar_full),
        .empty   (ar_empty)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            rid_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rid_q      <= rid_d;
        end
    end

    // An idle FSM takes a fresh AR straight from the bus to save a cycle.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rid_d      = rid_q;
        ar_pop     = 1'b0;
        bypass     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ar_empty) begin
                    ar_pop              = 1'b1;
                    {rid_d, beat_cnt_d} = ar_head;
                    state_d             = BURST;
                end else if (ar_hs) begin
                    bypass     = 1'b1;
                    rid_d      = s_arid;
                    beat_cnt_d = s_arlen;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (r_hs && !s_rlast) begin
                    beat_cnt_d = beat_cnt_q - 1'b1;
                end else if (r_hs) begin
                    if (!ar_empty) begin
                        ar_pop              = 1'b1;
                        {rid_d, beat_cnt_d} = ar_head;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_rvalid = (state_q == BURST);
        s_rlast  = s_rvalid && (beat_cnt_q == '0);
        s_rid    = rid_q;
        s_rdata  = RDATA_FILL;
        s_rresp  = RESP;
    end

endmodule
